// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store RAM initiator: size codes, FSM states,
// byte-mask and misalignment helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Reserved size is reported through the same error path as misalignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic e;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = off[0];
            SZ_WORD: e = (off != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_access_master_lsu_lane_extract.sv
// Load-data lane selection with sign/zero extension; purely combinational.
module lsu_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: result_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: result_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_master.sv
// Load/store initiator owning the single-cycle data RAM port.
// Define MEM_ACCESS_SYNC_RAM_EN for a RAM with registered read (adds a WAIT state).
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              ram_en_q;
    logic [3:0]        ram_wen_q;

    logic              req_err;
    logic [31:0]       wdata_rep;
    logic [31:0]       load_data;
    logic [31:0]       rsp_rdata_d;

    assign req_err = misaligned(req_size, req_addr[1:0]);

    // Store data is replicated across lanes at accept time so the RAM bus holds it afterwards.
    always_comb begin
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    lsu_lane_extract u_extract (
        .rdata_i  (ram_rdata),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .result_o (load_data)
    );

    assign rsp_rdata_d = wr_q ? 32'd0 : load_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            ram_en_q    <= 1'b0;
            ram_wen_q   <= 4'b0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q     <= req_wr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= wdata_rep;
                        if (req_err) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            state_q   <= ST_ACCESS;
                            ram_en_q  <= 1'b1;
                            ram_wen_q <= req_wr ? byte_mask(req_size, req_addr[1:0]) : 4'b0000;
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_en_q  <= 1'b0;
                    ram_wen_q <= 4'b0000;
`ifdef MEM_ACCESS_SYNC_RAM_EN
                    state_q   <= ST_WAIT;
`else
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= rsp_rdata_d;
`endif
                end
                ST_WAIT: begin
`ifdef MEM_ACCESS_SYNC_RAM_EN
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= rsp_rdata_d;
`else
                    state_q     <= ST_IDLE;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ram_en    = ram_en_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = addr_q[ADDR_W+1:2];
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: directed scenarios plus randomized
// traffic checked against a byte-addressed memory model.
module tb_mem_access_master;

    localparam int ADDR_W = 10;
    localparam int WORDS  = 1 << ADDR_W;
`ifdef MEM_ACCESS_SYNC_RAM_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    always #5 clk = ~clk;

    mem_access_master #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // ---------------- RAM attached to the DUT ----------------
    logic [31:0] ram [0:WORDS-1];
    logic        fill = 1'b1;

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] x;
        x = 32'(w) * 32'h9E3779B1 + 32'h01234567;
        return x ^ (x >> 13);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int w = 0; w < WORDS; w++) ram[w] <= init_word(w);
        end else if (ram_en) begin
            ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_wen);
        end
    end

`ifdef MEM_ACCESS_SYNC_RAM_EN
    always @(posedge clk) ram_rdata <= ram[ram_addr];
`else
    assign ram_rdata = ram[ram_addr];
`endif

    // ---------------- Reference model (byte memory) ----------------
    logic [7:0] ref_mem [0:4*WORDS-1];

    function automatic bit m_err(input logic [1:0] sz, input logic [11:0] a);
        int n;
        n = 1 << sz;
        return (sz == 2'd3) || ((int'(a) % n) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [11:0] a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] m_wen(input logic [1:0] sz, input logic [11:0] a);
        int n, off;
        logic [3:0] m;
        n = 1 << sz;
        off = int'(a) % 4;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'((wd >> (8 * (i % n))) & 32'hFF);
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] wd);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    // ---------------- Counters and observations ----------------
    int n_vec = 0;
    int n_err = 0;

    int          acc_wait, lat, en_cnt;
    logic [3:0]  o_wen;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata, o_rdata;
    logic        o_err;
    bit          o_stable, o_after;

    // Drives one request and records what the DUT did; callers do the checking.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [11:0] addr, input logic [31:0] wd,
                           input int stall, input bit early);
        acc_wait = 0; lat = -1; en_cnt = 0; o_wen = 4'b0000; o_addr = '0;
        o_wdata = 32'd0; o_rdata = 32'd0; o_err = 1'b0; o_stable = 1'b1; o_after = 1'b0;
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; rsp_ready = early;
        while (!req_ready && acc_wait < 20) begin
            @(negedge clk);
            acc_wait++;
        end
        if (!req_ready) begin
            req_valid = 1'b0; rsp_ready = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (ram_en) begin
                en_cnt++;
                o_wen = ram_wen; o_addr = ram_addr; o_wdata = ram_wdata;
            end
            if (rsp_valid) lat = c;
        end
        if (lat < 0) begin
            rsp_ready = 1'b0;
            return;
        end
        o_rdata = rsp_rdata;
        o_err   = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_rdata === o_rdata && rsp_err === o_err &&
                  req_ready === 1'b0 && ram_en === 1'b0)) o_stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o_after = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        resetn = 1'b0; fill = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10;
        req_addr = 12'h014; req_wdata = $urandom; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        n_vec++; if (ram_en !== 1'b0) begin n_err++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        n_vec++; if (ram_wen !== 4'b0000) begin n_err++; $display("FAIL reset_ram_wen got=%b exp=0000", ram_wen); end
        n_vec++; if (ram_addr !== '0) begin n_err++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        n_vec++; if (ram_wdata !== 32'd0) begin n_err++; $display("FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
        req_valid = 1'b0; rsp_ready = 1'b0; fill = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid);
        end
        $display("reset: idle outputs checked");
    endtask

    task automatic test_word_store();
        run_req(1'b1, 2'b10, 1'b0, 12'h014, 32'h8899AABB, 0, 1'b0);
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL wstore_latency got=%0d exp=%0d", lat, LAT); end
        n_vec++; if (en_cnt !== 1) begin n_err++; $display("FAIL wstore_en_cycles got=%0d exp=1", en_cnt); end
        n_vec++; if (o_wen !== 4'b1111) begin n_err++; $display("FAIL wstore_wen got=%b exp=1111", o_wen); end
        n_vec++; if (o_addr !== 10'd5) begin n_err++; $display("FAIL wstore_addr got=%0d exp=5", o_addr); end
        n_vec++; if (o_wdata !== 32'h8899AABB) begin n_err++; $display("FAIL wstore_wdata got=%h exp=8899aabb", o_wdata); end
        n_vec++; if (o_err !== 1'b0 || o_rdata !== 32'd0) begin
            n_err++; $display("FAIL wstore_rsp got err=%b rdata=%h exp err=0 rdata=0", o_err, o_rdata);
        end
        n_vec++; if (!o_after) begin n_err++; $display("FAIL wstore_release got=0 exp=1"); end
        m_store(2'b10, 12'h014, 32'h8899AABB);
        $display("word store 0x014 <- 8899aabb lat=%0d", lat);
    endtask

    task automatic test_byte_load();
        run_req(1'b0, 2'b00, 1'b1, 12'h015, 32'hFFFFFFFF, 0, 1'b0);
        n_vec++; if (o_rdata !== 32'hFFFFFFAA) begin n_err++; $display("FAIL bload_signed got=%h exp=ffffffaa", o_rdata); end
        n_vec++; if (en_cnt !== 1 || o_wen !== 4'b0000) begin
            n_err++; $display("FAIL bload_ram got en=%0d wen=%b exp en=1 wen=0000", en_cnt, o_wen);
        end
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL bload_latency got=%0d exp=%0d", lat, LAT); end
        $display("byte load 0x015 signed -> %h", o_rdata);
        run_req(1'b0, 2'b00, 1'b0, 12'h015, 32'd0, 0, 1'b0);
        n_vec++; if (o_rdata !== 32'h000000AA) begin n_err++; $display("FAIL bload_unsigned got=%h exp=000000aa", o_rdata); end
        $display("byte load 0x015 unsigned -> %h", o_rdata);
    endtask

    task automatic test_half_store();
        run_req(1'b1, 2'b01, 1'b0, 12'h016, 32'hDEAD1234, 0, 1'b0);
        n_vec++; if (o_wen !== 4'b1100) begin n_err++; $display("FAIL hstore_wen got=%b exp=1100", o_wen); end
        n_vec++; if (o_wdata !== 32'h12341234) begin n_err++; $display("FAIL hstore_wdata got=%h exp=12341234", o_wdata); end
        m_store(2'b01, 12'h016, 32'hDEAD1234);
        $display("half store 0x016 <- 1234");
        run_req(1'b0, 2'b10, 1'b0, 12'h014, 32'd0, 0, 1'b0);
        n_vec++; if (o_rdata !== 32'h1234AABB) begin n_err++; $display("FAIL hstore_readback got=%h exp=1234aabb", o_rdata); end
        $display("word load 0x014 -> %h", o_rdata);
    endtask

    task automatic test_errors();
        logic [1:0]  sz [3];
        logic [11:0] ad [3];
        logic        wr [3];
        sz = '{2'b10, 2'b11, 2'b01};
        ad = '{12'h016, 12'h014, 12'h015};
        wr = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            run_req(wr[k], sz[k], 1'b1, ad[k], 32'h5A5A5A5A, 0, 1'b0);
            n_vec++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin
                n_err++; $display("FAIL err_rsp[%0d] got err=%b rdata=%h exp err=1 rdata=0", k, o_err, o_rdata);
            end
            n_vec++; if (en_cnt !== 0) begin n_err++; $display("FAIL err_no_access[%0d] got=%0d exp=0", k, en_cnt); end
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL err_latency[%0d] got=%0d exp=1", k, lat); end
            $display("error req size=%b addr=%h -> err=%b", sz[k], ad[k], o_err);
        end
        run_req(1'b0, 2'b10, 1'b0, 12'h014, 32'd0, 0, 1'b0);
        n_vec++; if (o_rdata !== 32'h1234AABB) begin n_err++; $display("FAIL err_mem_intact got=%h exp=1234aabb", o_rdata); end
    endtask

    task automatic test_stall();
        run_req(1'b0, 2'b10, 1'b0, 12'h014, 32'd0, 5, 1'b0);
        n_vec++; if (!o_stable) begin n_err++; $display("FAIL stall_stable got=0 exp=1"); end
        n_vec++; if (o_rdata !== 32'h1234AABB) begin n_err++; $display("FAIL stall_rdata got=%h exp=1234aabb", o_rdata); end
        n_vec++; if (!o_after) begin n_err++; $display("FAIL stall_release got=0 exp=1"); end
        $display("stalled load 0x014 -> %h", o_rdata);
        run_req(1'b0, 2'b10, 1'b0, 12'h018, 32'd0, 0, 1'b1);
        n_vec++; if (acc_wait !== 0) begin n_err++; $display("FAIL b2b_accept_wait got=%0d exp=0", acc_wait); end
        n_vec++; if (o_rdata !== m_load(2'b10, 1'b0, 12'h018)) begin
            n_err++; $display("FAIL b2b_rdata got=%h exp=%h", o_rdata, m_load(2'b10, 1'b0, 12'h018));
        end
        $display("back-to-back load 0x018 -> %h", o_rdata);
    endtask

    task automatic test_reset_mid_access();
        int seen;
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 12'h014; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (ram_en !== 1'b1) begin n_err++; $display("FAIL midrst_access got=%b exp=1", ram_en); end
        resetn = 1'b0;
        #1;
        n_vec++; if (ram_en !== 1'b0 || ram_wen !== 4'b0000) begin
            n_err++; $display("FAIL midrst_drop got en=%b wen=%b exp en=0 wen=0000", ram_en, ram_wen);
        end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
        run_req(1'b0, 2'b10, 1'b0, 12'h014, 32'd0, 0, 1'b0);
        n_vec++; if (o_rdata !== 32'h1234AABB) begin n_err++; $display("FAIL midrst_mem got=%h exp=1234aabb", o_rdata); end
        $display("reset during store access: word 0x014 = %h", o_rdata);
    endtask

    task automatic test_random();
        logic        wr, sg;
        logic [1:0]  sz;
        logic [11:0] ad;
        logic [31:0] wd, e_rd;
        int          stall;
        bit          early, e_err;
        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = 12'($urandom_range(0, 63));
            wd = $urandom;
            early = ($urandom_range(0, 3) == 0);
            stall = early ? 0 : int'($urandom_range(0, 3));
            e_err = m_err(sz, ad);
            e_rd = (e_err || wr) ? 32'd0 : m_load(sz, sg, ad);
            run_req(wr, sz, sg, ad, wd, stall, early);
            n_vec++; if (lat !== (e_err ? 1 : LAT)) begin n_err++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, lat, e_err ? 1 : LAT); end
            n_vec++; if (en_cnt !== (e_err ? 0 : 1)) begin n_err++; $display("FAIL rnd%0d_en got=%0d exp=%0d", t, en_cnt, e_err ? 0 : 1); end
            n_vec++; if (o_err !== e_err) begin n_err++; $display("FAIL rnd%0d_err got=%b exp=%b", t, o_err, e_err); end
            n_vec++; if (o_rdata !== e_rd) begin n_err++; $display("FAIL rnd%0d_rdata got=%h exp=%h", t, o_rdata, e_rd); end
            n_vec++; if (!o_stable || !o_after) begin
                n_err++; $display("FAIL rnd%0d_handshake got stable=%b release=%b exp 1/1", t, o_stable, o_after);
            end
            if (!e_err) begin
                n_vec++; if (o_addr !== ad[11:2] || o_wen !== (wr ? m_wen(sz, ad) : 4'b0000)) begin
                    n_err++; $display("FAIL rnd%0d_ram got addr=%h wen=%b exp addr=%h wen=%b", t, o_addr, o_wen,
                                      ad[11:2], wr ? m_wen(sz, ad) : 4'b0000);
                end
                if (wr) begin
                    n_vec++; if (o_wdata !== m_wdata(sz, wd)) begin
                        n_err++; $display("FAIL rnd%0d_wdata got=%h exp=%h", t, o_wdata, m_wdata(sz, wd));
                    end
                    m_store(sz, ad, wd);
                end
            end
            $display("txn %0d: %s size=%b signed=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
                     t, wr ? "st" : "ld", sz, sg, ad, wd, o_rdata, o_err, lat);
        end
    endtask

    task automatic test_memory_image();
        logic [31:0] e;
        for (int w = 0; w < 16; w++) begin
            e = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            n_vec++; if (ram[w] !== e) begin n_err++; $display("FAIL mem_word%0d got=%h exp=%h", w, ram[w], e); end
        end
        $display("memory image words 0..15 compared");
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = 8'((init_word(w) >> (8 * b)) & 32'hFF);
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store();
        test_errors();
        test_stall();
        test_reset_mid_access();
        test_random();
        test_memory_image();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
